// File: rtl/battousai_mem_pkg.sv
// Shared decode constants, FSM states and size/alignment helpers for the
// multicycle data-memory access stage.
package battousai_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_bytes = 4'd1;
      F3_H, F3_HU: size_bytes = 4'd2;
      F3_W, F3_WU: size_bytes = 4'd4;
      default:     size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic align_ok(input logic [2:0] funct3, input logic [2:0] off);
    case (size_bytes(funct3))
      4'd1:    align_ok = 1'b1;
      4'd2:    align_ok = (off[0] == 1'b0);
      4'd4:    align_ok = (off[1:0] == 2'b00);
      default: align_ok = (off == 3'b000);
    endcase
  endfunction

  // Right-justified lane mask covering the access size.
  function automatic logic [63:0] size_mask(input logic [2:0] funct3);
    case (size_bytes(funct3))
      4'd1:    size_mask = 64'h0000_0000_0000_00FF;
      4'd2:    size_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/battousai_store_merge.sv
// Inserts the low bytes of store_data into old_word at byte offset off,
// sized by funct3. Purely combinational.
module battousai_store_merge
  import battousai_mem_pkg::*;
(
  input  logic [63:0] old_word,
  input  logic [63:0] store_data,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] merged_word
);

  logic [5:0]  shamt;
  logic [63:0] lane_mask;

  assign shamt       = {off, 3'b000};
  assign lane_mask   = size_mask(funct3) << shamt;
  assign merged_word = (old_word & ~lane_mask) | ((store_data << shamt) & lane_mask);

endmodule

// File: rtl/battousai_mem_access.sv
// Multicycle load/store stage driving a 64-bit doubleword memory without
// byte enables; partial stores are done as read-modify-write.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for start; request decoded and latched here
//   ST_READ  | mem_re held for MEM_LAT cycles, data sampled on last
//   ST_WRITE | single mem_we cycle (sd or merged partial store)
//   ST_DONE  | one-cycle done pulse, start ignored
module battousai_mem_access
  import battousai_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic [63:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [63:0] Dataout,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] sdata_q, sdata_d;
  logic [63:0] data_q, data_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        req_load;
  logic        req_store;
  logic [63:0] load_word;
  logic [63:0] merged_word;
  logic        unused_instr;

  assign opc          = instr[6:0];
  assign f3           = instr[14:12];
  assign req_load     = (opc == OP_LOAD) && (f3 != 3'd7);
  assign req_store    = (opc == OP_STORE) && !f3[2];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign load_word = (mem_rdata >> {addr_q[2:0], 3'b000}) & size_mask(f3_q);

  battousai_store_merge u_merge (
    .old_word    (mem_rdata),
    .store_data  (sdata_q),
    .off         (addr_q[2:0]),
    .funct3      (f3_q),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    data_d    = data_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    ill_d     = ill_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_load_d = req_load;
          f3_d      = f3;
          addr_d    = addr;
          sdata_d   = store_data;
          mis_d     = 1'b0;
          ill_d     = 1'b0;
          if (!(req_load || req_store)) begin
            ill_d   = 1'b1;
            state_d = ST_DONE;
          end else if (!align_ok(f3, addr[2:0])) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else if (req_store && (f3 == F3_D)) begin
            wdata_d = store_data;
            state_d = ST_WRITE;
          end else begin
            cnt_d   = 4'(MEM_LAT - 1);
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (cnt_q == 4'd0) begin
          if (is_load_q) begin
            data_d  = load_word;
            state_d = ST_DONE;
          end else begin
            wdata_d = merged_word;
            state_d = ST_WRITE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      is_load_q <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 64'd0;
      sdata_q   <= 64'd0;
      data_q    <= 64'd0;
      wdata_q   <= 64'd0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      data_q    <= data_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
    end
  end

  assign mem_addr   = {addr_q[63:3], 3'b000};
  assign mem_re     = (state_q == ST_READ);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_wdata  = wdata_q;
  assign Dataout    = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign misaligned = mis_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_battousai_mem_access.sv
// Bench for battousai_mem_access: one instance at MEM_LAT=1, one at MEM_LAT=4,
// each backed by a small latency-accurate doubleword memory model.
module tb_battousai_mem_access;

  logic        clk;
  logic        reset_n    [2];
  logic        start      [2];
  logic [31:0] instr      [2];
  logic [63:0] addr       [2];
  logic [63:0] store_data [2];
  logic [63:0] mem_addr   [2];
  logic        mem_re     [2];
  logic        mem_we     [2];
  logic [63:0] mem_wdata  [2];
  logic [63:0] mem_rdata  [2];
  logic [63:0] Dataout    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        misaligned [2];
  logic        illegal    [2];

  logic [63:0] mem [2][64];
  int          re_run   [2] = '{0, 0};
  int          we_total [2] = '{0, 0};
  logic        poke_en  = 1'b0;
  int          poke_sel = 0;
  logic [5:0]  poke_idx = 6'd0;
  logic [63:0] poke_val = 64'd0;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_dout [2];

  battousai_mem_access #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n[0]), .start(start[0]), .instr(instr[0]),
    .addr(addr[0]), .store_data(store_data[0]), .mem_addr(mem_addr[0]),
    .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .Dataout(Dataout[0]), .busy(busy[0]),
    .done(done[0]), .misaligned(misaligned[0]), .illegal(illegal[0])
  );

  battousai_mem_access #(.MEM_LAT(4)) dut4 (
    .clk(clk), .reset_n(reset_n[1]), .start(start[1]), .instr(instr[1]),
    .addr(addr[1]), .store_data(store_data[1]), .mem_addr(mem_addr[1]),
    .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .Dataout(Dataout[1]), .busy(busy[1]),
    .done(done[1]), .misaligned(misaligned[1]), .illegal(illegal[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only valid in the MEM_LAT-th consecutive mem_re cycle.
  assign mem_rdata[0] = (mem_re[0] && re_run[0] == 0) ? mem[0][mem_addr[0][8:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
  assign mem_rdata[1] = (mem_re[1] && re_run[1] == 3) ? mem[1][mem_addr[1][8:3]] : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (poke_en && poke_sel == s) mem[s][poke_idx] <= poke_val;
      if (mem_we[s]) begin
        mem[s][mem_addr[s][8:3]] <= mem_wdata[s];
        we_total[s] <= we_total[s] + 1;
      end
      re_run[s] <= mem_re[s] ? re_run[s] + 1 : 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0A5A5, f3, 5'b10101, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int s, input int idx, input logic [63:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = s; poke_idx = idx[5:0]; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference behaviour computed bytewise from the memory model contents.
  task automatic model(input int sel, input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd,
                       output logic [63:0] e_data, output int e_re, output int e_we,
                       output logic [63:0] e_wdata, output int e_done,
                       output logic e_mis, output logic e_ill);
    int size, off, lat;
    logic [63:0] old, nw;
    lat  = (sel == 1) ? 4 : 1;
    size = 1 << (f3 % 4);
    off  = int'(a % 8);
    old  = mem[sel][a[8:3]];
    e_data = exp_dout[sel]; e_re = 0; e_we = 0; e_wdata = 64'd0; e_mis = 1'b0; e_ill = 1'b0;
    if (!((op == 7'd3 && f3 != 3'd7) || (op == 7'd35 && f3 < 3'd4))) begin
      e_ill = 1'b1; e_done = 1;
    end else if (off % size != 0) begin
      e_mis = 1'b1; e_done = 1;
    end else if (op == 7'd3) begin
      e_data = 64'd0;
      for (int b = 0; b < size; b++) e_data[8*b +: 8] = old[8*(off+b) +: 8];
      e_re = lat; e_done = lat + 1;
    end else if (size == 8) begin
      e_we = 1; e_wdata = sd; e_done = 2;
    end else begin
      nw = old;
      for (int b = 0; b < size; b++) nw[8*(off+b) +: 8] = sd[8*b +: 8];
      e_re = lat; e_we = 1; e_wdata = nw; e_done = lat + 2;
    end
  endtask

  task automatic run_req(input int sel, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd,
                         input logic [63:0] e_data, input int e_re, input int e_we,
                         input logic [63:0] e_wdata, input int e_done,
                         input logic e_mis, input logic e_ill, input string nm);
    int re_n, we_n, done_n, done_at, busy_n;
    logic [63:0] wd;
    logic addr_ok;
    re_n = 0; we_n = 0; done_n = 0; done_at = 0; busy_n = 0; wd = 64'd0; addr_ok = 1'b1;
    @(negedge clk);
    start[sel] = 1'b1; instr[sel] = mk(op, f3); addr[sel] = a; store_data[sel] = sd;
    @(negedge clk);
    start[sel] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (mem_re[sel]) begin
        re_n++;
        if (mem_addr[sel] !== (a & ~64'h7)) addr_ok = 1'b0;
      end
      if (mem_we[sel]) begin
        we_n++;
        wd = mem_wdata[sel];
        if (mem_addr[sel] !== (a & ~64'h7)) addr_ok = 1'b0;
      end
      if (busy[sel]) busy_n++;
      if (done[sel]) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (done_at != 0 && k > done_at) break;
      @(negedge clk);
    end
    chk({nm, " done_cycle"}, 64'(done_at), 64'(e_done));
    chk({nm, " done_pulses"}, 64'(done_n), 64'd1);
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'(e_done));
    chk({nm, " re_cycles"}, 64'(re_n), 64'(e_re));
    chk({nm, " we_cycles"}, 64'(we_n), 64'(e_we));
    if (e_we != 0) chk({nm, " wdata"}, wd, e_wdata);
    chk({nm, " mem_addr"}, 64'(addr_ok), 64'd1);
    chk({nm, " Dataout"}, Dataout[sel], e_data);
    chk({nm, " misaligned"}, 64'(misaligned[sel]), 64'(e_mis));
    chk({nm, " illegal"}, 64'(illegal[sel]), 64'(e_ill));
  endtask

  typedef struct {
    int          sel;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] sd;
    logic [63:0] e_data;
    int          e_re;
    int          e_we;
    logic [63:0] e_wdata;
    int          e_done;
    logic        e_mis;
    logic        e_ill;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int re_n, done_n, done_at, busy_n, we_seen, wt;
    logic [63:0] e_data, e_wdata, r_a, r_sd;
    int e_re, e_we, e_done, r_sel, r_kind;
    logic e_mis, e_ill;
    logic [6:0] r_op;
    logic [2:0] r_f3;

    tbl[0]  = '{0, 7'd3,  3'd3, 64'h10, 64'h0, 64'h1122334455667788, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[1]  = '{0, 7'd3,  3'd0, 64'h13, 64'h0, 64'h0000000000000055, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[2]  = '{0, 7'd3,  3'd1, 64'h16, 64'h0, 64'h0000000000001122, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[3]  = '{0, 7'd35, 3'd0, 64'h11, 64'hAB, 64'h1122, 1, 1, 64'h112233445566AB88, 3, 1'b0, 1'b0};
    tbl[4]  = '{0, 7'd35, 3'd3, 64'h18, 64'hCAFEF00D12345678, 64'h1122, 0, 1, 64'hCAFEF00D12345678, 2, 1'b0, 1'b0};
    tbl[5]  = '{0, 7'd3,  3'd2, 64'h12, 64'h0, 64'h1122, 0, 0, 64'h0, 1, 1'b1, 1'b0};
    tbl[6]  = '{0, 7'd51, 3'd0, 64'h10, 64'h0, 64'h1122, 0, 0, 64'h0, 1, 1'b0, 1'b1};
    tbl[7]  = '{0, 7'd3,  3'd3, 64'h10, 64'h0, 64'h112233445566AB88, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[8]  = '{0, 7'd3,  3'd3, 64'h18, 64'h0, 64'hCAFEF00D12345678, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[9]  = '{0, 7'd3,  3'd0, 64'h17, 64'h0, 64'h0000000000000011, 1, 0, 64'h0, 2, 1'b0, 1'b0};
    tbl[10] = '{0, 7'd3,  3'd7, 64'h10, 64'h0, 64'h11, 0, 0, 64'h0, 1, 1'b0, 1'b1};
    tbl[11] = '{0, 7'd35, 3'd4, 64'h10, 64'h5, 64'h11, 0, 0, 64'h0, 1, 1'b0, 1'b1};
    tbl[12] = '{0, 7'd35, 3'd3, 64'h1C, 64'h5, 64'h11, 0, 0, 64'h0, 1, 1'b1, 1'b0};
    tbl[13] = '{0, 7'd35, 3'd1, 64'h15, 64'h5, 64'h11, 0, 0, 64'h0, 1, 1'b1, 1'b0};
    tbl[14] = '{1, 7'd3,  3'd5, 64'h20, 64'h0, 64'h000000000000CDEF, 4, 0, 64'h0, 5, 1'b0, 1'b0};
    tbl[15] = '{1, 7'd35, 3'd2, 64'h24, 64'hDEADBEEF, 64'hCDEF, 4, 1, 64'hDEADBEEF89ABCDEF, 6, 1'b0, 1'b0};
    tbl[16] = '{1, 7'd3,  3'd6, 64'h24, 64'h0, 64'h00000000DEADBEEF, 4, 0, 64'h0, 5, 1'b0, 1'b0};
    tbl[17] = '{1, 7'd35, 3'd1, 64'h22, 64'h5A5A, 64'hDEADBEEF, 4, 1, 64'hDEADBEEF5A5ACDEF, 6, 1'b0, 1'b0};
    tbl[18] = '{1, 7'd3,  3'd3, 64'h20, 64'h0, 64'hDEADBEEF5A5ACDEF, 4, 0, 64'h0, 5, 1'b0, 1'b0};

    for (int s = 0; s < 2; s++) begin
      reset_n[s] = 1'b0; start[s] = 1'b0; instr[s] = 32'd0;
      addr[s] = 64'd0; store_data[s] = 64'd0; exp_dout[s] = 64'd0;
    end

    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 64; k++) poke(s, k, {$urandom, $urandom});
    poke(0, 2, 64'h1122334455667788);
    poke(1, 4, 64'h0123456789ABCDEF);

    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d busy", s), 64'(busy[s]), 64'd0);
      chk($sformatf("rst%0d mem_re", s), 64'(mem_re[s]), 64'd0);
      chk($sformatf("rst%0d mem_we", s), 64'(mem_we[s]), 64'd0);
      chk($sformatf("rst%0d done", s), 64'(done[s]), 64'd0);
      chk($sformatf("rst%0d Dataout", s), Dataout[s], 64'd0);
      chk($sformatf("rst%0d mem_addr", s), mem_addr[s], 64'd0);
      chk($sformatf("rst%0d mem_wdata", s), mem_wdata[s], 64'd0);
      chk($sformatf("rst%0d misaligned", s), 64'(misaligned[s]), 64'd0);
      chk($sformatf("rst%0d illegal", s), 64'(illegal[s]), 64'd0);
    end
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_req(tbl[i].sel, tbl[i].op, tbl[i].f3, tbl[i].a, tbl[i].sd, tbl[i].e_data,
              tbl[i].e_re, tbl[i].e_we, tbl[i].e_wdata, tbl[i].e_done,
              tbl[i].e_mis, tbl[i].e_ill, $sformatf("tbl%0d", i));
      exp_dout[tbl[i].sel] = tbl[i].e_data;
    end

    // lhu at MEM_LAT=4 with stray starts during READ and during DONE
    re_n = 0; done_n = 0; done_at = 0; busy_n = 0; we_seen = 0;
    @(negedge clk);
    start[1] = 1'b1; instr[1] = mk(7'd3, 3'd5); addr[1] = 64'h20;
    @(negedge clk);
    instr[1] = mk(7'd51, 3'd0); addr[1] = 64'h3;
    for (int k = 1; k <= 10; k++) begin
      if (mem_re[1]) re_n++;
      if (mem_we[1]) we_seen++;
      if (busy[1]) busy_n++;
      if (done[1]) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      start[1] = (k == 1 || k == 5);
      @(negedge clk);
    end
    start[1] = 1'b0;
    chk("busy_start done_cycle", 64'(done_at), 64'd5);
    chk("busy_start done_pulses", 64'(done_n), 64'd1);
    chk("busy_start re_cycles", 64'(re_n), 64'd4);
    chk("busy_start we_cycles", 64'(we_seen), 64'd0);
    chk("busy_start busy_cycles", 64'(busy_n), 64'd5);
    chk("busy_start illegal", 64'(illegal[1]), 64'd0);
    chk("busy_start Dataout", Dataout[1], 64'h000000000000CDEF);
    exp_dout[1] = 64'h000000000000CDEF;

    for (int n = 0; n < 80; n++) begin
      r_sel  = int'($urandom_range(0, 1));
      r_kind = int'($urandom_range(0, 9));
      r_op   = (r_kind < 5) ? 7'd3 : (r_kind < 9) ? 7'd35 : 7'($urandom_range(36, 127));
      r_f3   = 3'($urandom_range(0, 7));
      r_a    = 64'($urandom_range(0, 511)) | (64'($urandom_range(0, 3)) << 40);
      r_sd   = {$urandom, $urandom};
      model(r_sel, r_op, r_f3, r_a, r_sd, e_data, e_re, e_we, e_wdata, e_done, e_mis, e_ill);
      run_req(r_sel, r_op, r_f3, r_a, r_sd, e_data, e_re, e_we, e_wdata, e_done,
              e_mis, e_ill, $sformatf("rnd%0d", n));
      exp_dout[r_sel] = e_data;
    end

    // reset asserted during the READ cycle of a sw
    for (int s = 0; s < 2; s++) begin
      wt = we_total[s];
      we_seen = 0;
      @(negedge clk);
      start[s] = 1'b1; instr[s] = mk(7'd35, 3'd2); addr[s] = 64'h28; store_data[s] = 64'h77;
      @(negedge clk);
      start[s] = 1'b0;
      chk($sformatf("abort%0d in_read", s), 64'(mem_re[s]), 64'd1);
      reset_n[s] = 1'b0;
      @(negedge clk);
      chk($sformatf("abort%0d busy", s), 64'(busy[s]), 64'd0);
      chk($sformatf("abort%0d mem_re", s), 64'(mem_re[s]), 64'd0);
      chk($sformatf("abort%0d mem_we", s), 64'(mem_we[s]), 64'd0);
      chk($sformatf("abort%0d done", s), 64'(done[s]), 64'd0);
      chk($sformatf("abort%0d Dataout", s), Dataout[s], 64'd0);
      chk($sformatf("abort%0d mem_addr", s), mem_addr[s], 64'd0);
      chk($sformatf("abort%0d mem_wdata", s), mem_wdata[s], 64'd0);
      chk($sformatf("abort%0d misaligned", s), 64'(misaligned[s]), 64'd0);
      chk($sformatf("abort%0d illegal", s), 64'(illegal[s]), 64'd0);
      reset_n[s] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (mem_we[s]) we_seen++;
      end
      chk($sformatf("abort%0d late_we", s), 64'(we_seen), 64'd0);
      chk($sformatf("abort%0d mem_writes", s), 64'(we_total[s]), 64'(wt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
